alu_exec_seq: RTL and testbench
===============================

// Module: alu_exec_seq
// PURPOSE
//  Execute/write-back sequencer downstream of the 8x32 register bank. Takes one
//  op request and drives src1/src2 to the bank. Captures operands A/B, computes
//  the result (single-cycle ALU ops or a 32-step shift-add MUL), then returns
//  the result through Z/dest/WR for bank write-back.
// PARAMETERS
//  WIDTH  32  datapath width (A, B, Z, product truncated to WIDTH)
//  AW      3  register address width (8 registers)
// PORTS
//  clk    in   1      single clock, all state on posedge
//  rst    in   1      reset: asynchronous, active-low
//  start  in   1      request; sampled only in IDLE
//  op     in   4      opcode (table below)
//  rs1    in   AW     source 1 index
//  rs2    in   AW     source 2 index
//  rd     in   AW     destination index
//  A      in   WIDTH  operand 1 from bank (bank updates on negedge clk)
//  B      in   WIDTH  operand 2 from bank
//  src1   out  AW     read address 1 to bank
//  src2   out  AW     read address 2 to bank
//  dest   out  AW     write address to bank
//  Z      out  WIDTH  write data to bank
//  WR     out  1      write enable to bank, high exactly one cycle per legal op
//  busy   out  1      high whenever state != IDLE
//  done   out  1      one-cycle pulse after WB (or after an illegal op)
//  ovf    out  1      signed overflow of last ADD/SUB; held until next done
//  err    out  1      last op illegal; held until next done
// BEHAVIOUR
//  Clock and reset: one clock; reset is asynchronous and active-low.
//  Reset (rst=0, async): state=IDLE. WR, busy, done, ovf, err=0.
//   src1, src2, dest=0. Z=0. MUL counter=0.
//  Reset mid-operation: WR drops immediately and no write is issued.
//  Ops: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SLL A<<B[4:0],
//   7 SRL, 8 SRA, 9 SLT signed (Z=1/0), 10 MUL (low WIDTH bits, unsigned).
//   11..15 are illegal.
//  FSM: IDLE -> READ -> EXEC -> WB -> IDLE. Cycle n = interval after edge n.
//   IDLE: if start at edge 0, latch op/rs1/rs2/rd and drive src1=rs1,
//    src2=rs2. Go to READ in cycle 0. start in any other state is ignored.
//   READ (1 cycle): the bank presents A/B at the negedge. At edge 1, capture
//    A/B into internal operand registers and go to EXEC.
//   EXEC, non-MUL: 1 cycle. Z is registered at edge 2 and the FSM goes to WB.
//   EXEC, MUL: 32 cycles (cycles 1..32). Each cycle: if multiplier LSB is set,
//    add multiplicand into acc; then shift multiplicand left and multiplier
//    right. Counter runs 0..31. At edge 33, Z=acc and the FSM goes to WB.
//   EXEC, illegal op: no WB. Go straight to IDLE with done=1 and err=1 (cycle 2).
//   WB (1 cycle): WR=1, dest=rd, Z stable. The bank writes at the closing edge.
//    The next cycle is IDLE with done=1.
//  Latency, start edge to done: 3 cycles for ALU ops, 34 for MUL.
//   Earliest next start sample: the edge that ends the done cycle.
//  Arithmetic: all ops mod 2^WIDTH. ovf = (A[31]==B'[31]) && (Z[31]!=A[31]),
//   where B'=B for ADD and ~B+1 for SUB. ovf=0 for other ops.
//   Shift amount uses B[4:0] only.
//  rd==rs1 or rd==rs2 is legal. Operands are captured before the write.
//  Z, dest and ovf hold their values after WB until the next op's EXEC/WB.
// TESTING (bank reset values R[i]=i)
//  ADD rs1=3 rs2=5 rd=1, start at edge 0 -> WR=1 in cycle 2, Z=8, dest=1;
//   done in cycle 3; R1=8.
//  SUB rs1=2 rs2=7 rd=0 -> Z=32'hFFFFFFFB, ovf=0.
//   ADD with A=32'h7FFFFFFF, B=1 -> Z=32'h80000000, ovf=1.
//  MUL rs1=6 rs2=7 rd=4 -> busy held for cycles 0..33, WR only in cycle 33,
//   Z=42, done in cycle 34.
//  start pulsed again during MUL EXEC -> ignored (exactly one WR).
//   op=4'hF -> no WR, err=1, done in cycle 2.
//  Assert rst=0 in the middle of a MUL EXEC cycle -> WR/busy go to 0
//   immediately, no write. After release, a fresh ADD completes normally.
//  SRA rs1 loaded with 32'h80000000, B=4 -> Z=32'hF8000000.
//   SLT on (-1, 1) -> Z=1.

Source files
------------

// File: rtl/alu_exec_seq.sv
// alu_exec_seq: execute/write-back sequencer for the register bank; single-cycle ALU ops
// plus a WIDTH-step shift-add MUL, result returned via Z/dest/WR.
module alu_exec_seq #(
    parameter int WIDTH = 32,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    input  logic [AW-1:0]    rd,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [AW-1:0]    src1,
    output logic [AW-1:0]    src2,
    output logic [AW-1:0]    dest,
    output logic [WIDTH-1:0] Z,
    output logic             WR,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic             err
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
    state_t           r_state, w_next;
    logic [3:0]       r_op;
    logic [AW-1:0]    r_rd;
    logic [WIDTH-1:0] r_a, r_b, r_acc;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_bp, w_sum, w_alu, w_acc_nxt;
    logic [CW-1:0]    w_sh;
    logic             w_ill, w_mul, w_last, w_ovf;

    assign w_ill     = r_op > 4'd10;
    assign w_mul     = r_op == 4'd10;
    assign w_last    = r_cnt == CW'(WIDTH - 1);
    assign w_sh      = r_b[CW-1:0];
    assign w_bp      = (r_op == 4'd1) ? ~r_b + 1'b1 : r_b;
    assign w_sum     = r_a + w_bp;
    assign w_ovf     = (r_op < 4'd2) && (r_a[WIDTH-1] == w_bp[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
    assign w_acc_nxt = r_acc + (r_b[0] ? r_a : '0);
    assign WR        = r_state == WB;
    assign busy      = r_state != IDLE;

    always_comb begin
        w_alu = '0;
        case (r_op)
            4'd0, 4'd1: w_alu = w_sum;
            4'd2:       w_alu = r_a & r_b;
            4'd3:       w_alu = r_a | r_b;
            4'd4:       w_alu = r_a ^ r_b;
            4'd5:       w_alu = ~r_a;
            4'd6:       w_alu = r_a << w_sh;
            4'd7:       w_alu = r_a >> w_sh;
            4'd8:       w_alu = $signed(r_a) >>> w_sh;
            4'd9:       w_alu = {{(WIDTH-1){1'b0}}, $signed(r_a) < $signed(r_b)};
            default:    w_alu = '0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? READ : IDLE;
            READ:    w_next = EXEC;
            EXEC:    w_next = w_ill ? IDLE : (!w_mul || w_last) ? WB : EXEC;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op  <= '0;
            r_rd  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            src1  <= '0;
            src2  <= '0;
            dest  <= '0;
            Z     <= '0;
            done  <= 1'b0;
            ovf   <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_op <= op;
                    r_rd <= rd;
                    src1 <= rs1;
                    src2 <= rs2;
                end
                READ: begin
                    r_a   <= A;
                    r_b   <= B;
                    r_acc <= '0;
                    r_cnt <= '0;
                end
                EXEC: if (w_ill) begin
                    done <= 1'b1;
                    err  <= 1'b1;
                end else if (w_mul) begin
                    // multiplicand walks left, multiplier right; last step's sum goes straight to Z
                    r_acc <= w_acc_nxt;
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        Z    <= w_acc_nxt;
                        ovf  <= 1'b0;
                        dest <= r_rd;
                    end
                end else begin
                    Z    <= w_alu;
                    ovf  <= w_ovf;
                    dest <= r_rd;
                end
                default: begin
                    done <= 1'b1;
                    err  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_seq.sv
// tb_alu_exec_seq: directed bench for alu_exec_seq with a behavioural 8x32 register bank.
module tb_alu_exec_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = '0;
    logic [2:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic [31:0] A = '0, B = '0;
    logic [2:0]  src1, src2, dest;
    logic [31:0] Z;
    logic        WR, busy, done, ovf, err;
    logic [31:0] bank [8];
    int compared = 0;
    int mismatched = 0;

    alu_exec_seq dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2), .rd(rd),
        .A(A), .B(B), .src1(src1), .src2(src2), .dest(dest), .Z(Z),
        .WR(WR), .busy(busy), .done(done), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        A <= bank[src1];
        B <= bank[src2];
    end

    always @(posedge clk) if (WR) bank[dest] <= Z;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] d);
        op = o; rs1 = s1; rs2 = s2; rd = d; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Runs from cycle 0 until done, recording where WR appeared and whether busy behaved.
    task automatic wait_done(input int pulse_at, output int c_wr, output int c_done, output int n_wr,
                             output logic [31:0] z_wr, output logic [2:0] d_wr, output logic busy_ok);
        c_wr = -1; c_done = -1; n_wr = 0; z_wr = '0; d_wr = '0; busy_ok = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            start = (c == pulse_at);
            tick();
            start = 1'b0;
            if (WR) begin
                n_wr++;
                c_wr = c;
                z_wr = Z;
                d_wr = dest;
            end
            busy_ok &= done ? !busy : busy;
            if (done) begin
                c_done = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #3;
        compared++; if ({WR, busy, done, ovf, err} !== 5'b0) begin mismatched++; $display("FAIL reset_flags got=%b exp=00000", {WR, busy, done, ovf, err}); end
        compared++; if ({src1, src2, dest} !== 9'b0) begin mismatched++; $display("FAIL reset_addr got=%h exp=000", {src1, src2, dest}); end
        compared++; if (Z !== 32'h0) begin mismatched++; $display("FAIL reset_z got=%h exp=00000000", Z); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_add();
        int cw, cd, nw; logic [31:0] z; logic [2:0] d; logic bok;
        issue(4'd0, 3'd3, 3'd5, 3'd1);
        compared++; if ({busy, src1, src2} !== {1'b1, 3'd3, 3'd5}) begin mismatched++; $display("FAIL add_cycle0 got=%b exp=%b", {busy, src1, src2}, {1'b1, 3'd3, 3'd5}); end
        wait_done(0, cw, cd, nw, z, d, bok);
        compared++; if (cw !== 2) begin mismatched++; $display("FAIL add_wr_cycle got=%0d exp=2", cw); end
        compared++; if (z !== 32'd8) begin mismatched++; $display("FAIL add_z got=%h exp=8", z); end
        compared++; if (d !== 3'd1) begin mismatched++; $display("FAIL add_dest got=%0d exp=1", d); end
        compared++; if (cd !== 3) begin mismatched++; $display("FAIL add_done_cycle got=%0d exp=3", cd); end
        compared++; if ({nw, bok, ovf, err} !== {32'd1, 1'b1, 1'b0, 1'b0}) begin mismatched++; $display("FAIL add_misc nwr=%0d busy_ok=%b ovf=%b err=%b exp 1/1/0/0", nw, bok, ovf, err); end
        compared++; if (bank[1] !== 32'd8) begin mismatched++; $display("FAIL add_bank got=%h exp=8", bank[1]); end
    endtask

    task automatic test_sub_ovf();
        int cw, cd, nw; logic [31:0] z; logic [2:0] d; logic bok;
        issue(4'd1, 3'd2, 3'd7, 3'd0);
        wait_done(0, cw, cd, nw, z, d, bok);
        compared++; if ({z, ovf} !== {32'hFFFFFFFB, 1'b0}) begin mismatched++; $display("FAIL sub got z=%h ovf=%b exp z=fffffffb ovf=0", z, ovf); end
        compared++; if (bank[0] !== 32'hFFFFFFFB) begin mismatched++; $display("FAIL sub_bank got=%h exp=fffffffb", bank[0]); end
        bank[5] = 32'h7FFFFFFF; bank[6] = 32'd1;
        issue(4'd0, 3'd5, 3'd6, 3'd2);
        wait_done(0, cw, cd, nw, z, d, bok);
        compared++; if ({z, ovf} !== {32'h80000000, 1'b1}) begin mismatched++; $display("FAIL add_ovf got z=%h ovf=%b exp z=80000000 ovf=1", z, ovf); end
        bank[5] = 32'h80000000; bank[6] = 32'd1;
        issue(4'd1, 3'd5, 3'd6, 3'd2);
        wait_done(0, cw, cd, nw, z, d, bok);
        compared++; if ({z, ovf} !== {32'h7FFFFFFF, 1'b1}) begin mismatched++; $display("FAIL sub_ovf got z=%h ovf=%b exp z=7fffffff ovf=1", z, ovf); end
    endtask

    task automatic test_alu_table();
        logic [3:0]  ops [7] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        logic [31:0] exp [7] = '{32'h00F00024, 32'hFFF01234, 32'hFF001210, 32'h0F0FEDCB,
                                 32'h0F012340, 32'h0F0F0123, 32'hFF0F0123};
        int cw, cd, nw; logic [31:0] z; logic [2:0] d; logic bok;
        for (int i = 0; i < 7; i++) begin
            bank[1] = 32'hF0F01234; bank[2] = 32'h0FF00024;
            issue(ops[i], 3'd1, 3'd2, 3'd3);
            wait_done(0, cw, cd, nw, z, d, bok);
            compared++; if ({z, ovf, cd} !== {exp[i], 1'b0, 32'd3}) begin mismatched++; $display("FAIL alu_op%0d got z=%h ovf=%b done=%0d exp z=%h ovf=0 done=3", ops[i], z, ovf, cd, exp[i]); end
        end
    endtask

    task automatic test_sra_slt();
        int cw, cd, nw; logic [31:0] z; logic [2:0] d; logic bok;
        bank[1] = 32'h80000000; bank[2] = 32'd4;
        issue(4'd8, 3'd1, 3'd2, 3'd5);
        wait_done(0, cw, cd, nw, z, d, bok);
        compared++; if (z !== 32'hF8000000) begin mismatched++; $display("FAIL sra got=%h exp=f8000000", z); end
        bank[1] = 32'hFFFFFFFF; bank[2] = 32'd1;
        issue(4'd9, 3'd1, 3'd2, 3'd5);
        wait_done(0, cw, cd, nw, z, d, bok);
        compared++; if (z !== 32'd1) begin mismatched++; $display("FAIL slt got=%h exp=1", z); end
        issue(4'd9, 3'd2, 3'd1, 3'd5);
        wait_done(0, cw, cd, nw, z, d, bok);
        compared++; if (z !== 32'd0) begin mismatched++; $display("FAIL slt_rev got=%h exp=0", z); end
    endtask

    task automatic test_mul();
        int cw, cd, nw; logic [31:0] z; logic [2:0] d; logic bok;
        bank[6] = 32'd6; bank[7] = 32'd7;
        issue(4'd10, 3'd6, 3'd7, 3'd4);
        wait_done(10, cw, cd, nw, z, d, bok);
        compared++; if ({cw, nw} !== {32'd33, 32'd1}) begin mismatched++; $display("FAIL mul_wr got cycle=%0d count=%0d exp cycle=33 count=1", cw, nw); end
        compared++; if ({z, d} !== {32'd42, 3'd4}) begin mismatched++; $display("FAIL mul_z got z=%0d dest=%0d exp z=42 dest=4", z, d); end
        compared++; if ({cd, bok} !== {32'd34, 1'b1}) begin mismatched++; $display("FAIL mul_done got done=%0d busy_ok=%b exp done=34 busy_ok=1", cd, bok); end
        compared++; if (bank[4] !== 32'd42) begin mismatched++; $display("FAIL mul_bank got=%h exp=2a", bank[4]); end
        bank[6] = 32'hFFFFFFFF; bank[7] = 32'h00010003;
        issue(4'd10, 3'd6, 3'd7, 3'd4);
        wait_done(0, cw, cd, nw, z, d, bok);
        compared++; if (z !== 32'hFFFEFFFD) begin mismatched++; $display("FAIL mul_trunc got=%h exp=fffefffd", z); end
    endtask

    task automatic test_illegal();
        int cw, cd, nw; logic [31:0] z; logic [2:0] d; logic bok;
        issue(4'hF, 3'd1, 3'd2, 3'd3);
        wait_done(0, cw, cd, nw, z, d, bok);
        compared++; if ({nw, cd, err} !== {32'd0, 32'd2, 1'b1}) begin mismatched++; $display("FAIL illegal got nwr=%0d done=%0d err=%b exp 0/2/1", nw, cd, err); end
        bank[1] = 32'd10; bank[2] = 32'd20;
        issue(4'd0, 3'd1, 3'd2, 3'd1);
        wait_done(0, cw, cd, nw, z, d, bok);
        compared++; if ({err, bank[1]} !== {1'b0, 32'd30}) begin mismatched++; $display("FAIL back_to_back got err=%b r1=%0d exp err=0 r1=30", err, bank[1]); end
    endtask

    task automatic test_reset_abort();
        int cw, cd, nw; logic [31:0] z; logic [2:0] d; logic bok;
        int wrs = 0;
        bank[3] = 32'hAAAA5555; bank[6] = 32'd6; bank[7] = 32'd7;
        issue(4'd10, 3'd6, 3'd7, 3'd3);
        repeat (10) tick();
        #2 rst = 1'b0;
        #1;
        compared++; if ({WR, busy, done} !== 3'b0) begin mismatched++; $display("FAIL abort_mul got wr/busy/done=%b exp 000", {WR, busy, done}); end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 40; i++) begin tick(); wrs += int'(WR); end
        compared++; if ({wrs, bank[3]} !== {32'd0, 32'hAAAA5555}) begin mismatched++; $display("FAIL abort_mul_nowrite got wrs=%0d r3=%h exp 0 aaaa5555", wrs, bank[3]); end
        issue(4'd0, 3'd6, 3'd7, 3'd3);
        tick(); tick();
        compared++; if (WR !== 1'b1) begin mismatched++; $display("FAIL abort_wb_pre got WR=%b exp 1", WR); end
        #2 rst = 1'b0;
        #1;
        compared++; if ({WR, busy} !== 2'b0) begin mismatched++; $display("FAIL abort_wb got wr/busy=%b exp 00", {WR, busy}); end
        tick();
        rst = 1'b1;
        tick();
        compared++; if (bank[3] !== 32'hAAAA5555) begin mismatched++; $display("FAIL abort_wb_nowrite got r3=%h exp aaaa5555", bank[3]); end
        issue(4'd0, 3'd6, 3'd7, 3'd3);
        wait_done(0, cw, cd, nw, z, d, bok);
        compared++; if ({cw, cd, bank[3]} !== {32'd2, 32'd3, 32'd13}) begin mismatched++; $display("FAIL after_reset_add got wr=%0d done=%0d r3=%0d exp 2/3/13", cw, cd, bank[3]); end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) bank[i] = 32'(i);
        test_reset();
        test_add();
        test_sub_ovf();
        test_alu_table();
        test_sra_slt();
        test_mul();
        test_illegal();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
